// File: rtl/exhaustive_response_checker.sv
// Exhaustive-sweep response checker.
// Accepts one response bit per vector of a 2^N_IN sweep and folds the stream
// into a serial CRC signature. It also counts the ones and, when the sweep
// ends, compares the final signature with a golden value.
module exhaustive_response_checker #(
   parameter int unsigned       N_IN  = 9,
   parameter int unsigned       SIG_W = 16,
   parameter logic [SIG_W-1:0]  POLY  = 16'h1021,
   parameter logic [SIG_W-1:0]  SEED  = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              resp_valid,
   input  logic              resp_bit,
   input  logic [SIG_W-1:0]  expected_sig,
   output logic [N_IN-1:0]   vec_idx,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [SIG_W-1:0]  signature,
   output logic [N_IN:0]     ones_count
);

   localparam int unsigned CNT_W = N_IN + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [N_IN-1:0]    vec_idx_d;
   logic [SIG_W-1:0]   signature_d;
   logic [CNT_W-1:0]   ones_count_d;
   logic               pass_d;
   logic               busy_d;
   logic               done_d;

   logic               fb;
   logic [SIG_W-1:0]   sig_step;
   logic               last_vec;

   // One serial CRC step for the current response bit.
   always_comb begin
      fb       = signature[SIG_W-1] ^ resp_bit;
      sig_step = (signature << 1) ^ (fb ? POLY : '0);
      last_vec = (vec_idx == {N_IN{1'b1}});
   end

   // Next-state and next-output logic; all outputs are registered from these.
   always_comb begin
      state_d      = state_q;
      vec_idx_d    = vec_idx;
      signature_d  = signature;
      ones_count_d = ones_count;
      pass_d       = pass;
      busy_d       = 1'b0;
      done_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = RUN;
               signature_d  = SEED;
               vec_idx_d    = '0;
               ones_count_d = '0;
               pass_d       = 1'b0;
            end
         end

         RUN: begin
            if (resp_valid) begin
               signature_d  = sig_step;
               ones_count_d = ones_count + CNT_W'(resp_bit);
               vec_idx_d    = vec_idx + N_IN'(1);
               if (last_vec) begin
                  state_d = DONE;
                  pass_d  = (sig_step == expected_sig);
               end
            end
         end

         DONE: begin
            // single-cycle completion; any start here is dropped
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         vec_idx    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         signature  <= SEED;
         ones_count <= '0;
      end else begin
         state_q    <= state_d;
         vec_idx    <= vec_idx_d;
         busy       <= busy_d;
         done       <= done_d;
         pass       <= pass_d;
         signature  <= signature_d;
         ones_count <= ones_count_d;
      end
   end

endmodule

// File: tb/tb_exhaustive_response_checker.sv
// Self-checking bench: default configuration sweeps plus a small
// N_IN=2 / CRC-8 configuration driven from a vector table.
module tb_exhaustive_response_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // default configuration (N_IN=9, SIG_W=16)
   logic        start_a, valid_a, bit_a;
   logic [15:0] esig_a;
   logic [8:0]  vec_a;
   logic        busy_a, done_a, pass_a;
   logic [15:0] sig_a;
   logic [9:0]  ones_a;

   // small configuration (N_IN=2, SIG_W=8, POLY=07, SEED=00)
   logic        start_b, valid_b, bit_b;
   logic [7:0]  esig_b;
   logic [1:0]  vec_b;
   logic        busy_b, done_b, pass_b;
   logic [7:0]  sig_b;
   logic [2:0]  ones_b;

   int n_checks = 0;
   int n_err    = 0;

   exhaustive_response_checker dut_a (
      .clk          (clk),
      .rst          (rst),
      .start        (start_a),
      .resp_valid   (valid_a),
      .resp_bit     (bit_a),
      .expected_sig (esig_a),
      .vec_idx      (vec_a),
      .busy         (busy_a),
      .done         (done_a),
      .pass         (pass_a),
      .signature    (sig_a),
      .ones_count   (ones_a)
   );

   exhaustive_response_checker #(
      .N_IN  (2),
      .SIG_W (8),
      .POLY  (8'h07),
      .SEED  (8'h00)
   ) dut_b (
      .clk          (clk),
      .rst          (rst),
      .start        (start_b),
      .resp_valid   (valid_b),
      .resp_bit     (bit_b),
      .expected_sig (esig_b),
      .vec_idx      (vec_b),
      .busy         (busy_b),
      .done         (done_b),
      .pass         (pass_b),
      .signature    (sig_b),
      .ones_count   (ones_b)
   );

   typedef struct {
      logic       start;
      logic       valid;
      logic       bitv;
      logic [7:0] esig;
      logic [7:0] sig;
      logic [1:0] vec;
      logic [2:0] ones;
      logic       busy;
      logic       done;
      logic       pass;
   } row_t;

   row_t tbl[$];

   function automatic row_t mk(input logic st, input logic v, input logic b,
                               input logic [7:0] es, input logic [7:0] s,
                               input logic [1:0] vi, input logic [2:0] on,
                               input logic bz, input logic dn, input logic ps);
      row_t r;
      r.start = st; r.valid = v; r.bitv = b; r.esig = es;
      r.sig = s; r.vec = vi; r.ones = on; r.busy = bz; r.done = dn; r.pass = ps;
      return r;
   endfunction

   // Reference CRC-16 step for the default configuration.
   function automatic logic [15:0] crc16(input logic [15:0] s, input logic b);
      logic f;
      f = s[15] ^ b;
      return (s << 1) ^ (f ? 16'h1021 : 16'h0000);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
      end
   endtask

   // Full 2^9 sweep of constant bits with valid every cycle.
   task automatic sweep_a(input logic bitval, input string tag);
      logic [15:0] model;
      int busy_cnt;
      int done_cnt;
      model = 16'hFFFF;
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 512; i++) model = crc16(model, bitval);
      esig_a  = model;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      valid_a = 1'b1;
      bit_a   = bitval;
      chk({tag, "_busy_after_start"}, 32'(busy_a), 32'd1);
      if (busy_a) busy_cnt++;
      for (int i = 0; i < 511; i++) begin
         tick();
         if (busy_a) busy_cnt++;
         if (done_a) done_cnt++;
      end
      tick();
      valid_a = 1'b0;
      if (done_a) done_cnt++;
      if (busy_a) busy_cnt++;
      chk({tag, "_done"}, 32'(done_a), 32'd1);
      chk({tag, "_busy_in_done"}, 32'(busy_a), 32'd0);
      chk({tag, "_pass"}, 32'(pass_a), 32'd1);
      chk({tag, "_sig"}, 32'(sig_a), 32'(model));
      chk({tag, "_ones"}, 32'(ones_a), bitval ? 32'd512 : 32'd0);
      chk({tag, "_vec"}, 32'(vec_a), 32'd0);
      tick();
      if (done_a) done_cnt++;
      chk({tag, "_done_cleared"}, 32'(done_a), 32'd0);
      chk({tag, "_pass_hold"}, 32'(pass_a), 32'd1);
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd512);
      chk({tag, "_done_cycles"}, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      start_a = 1'b0; valid_a = 1'b0; bit_a = 1'b0; esig_a = 16'h0000;
      start_b = 1'b0; valid_b = 1'b0; bit_b = 1'b0; esig_b = 8'h00;
      tick();
      tick();
      rst = 1'b0;

      // reset state of both instances
      chk("rst_a_vec",  32'(vec_a),  32'd0);
      chk("rst_a_busy", 32'(busy_a), 32'd0);
      chk("rst_a_done", 32'(done_a), 32'd0);
      chk("rst_a_pass", 32'(pass_a), 32'd0);
      chk("rst_a_sig",  32'(sig_a),  32'h0000FFFF);
      chk("rst_a_ones", 32'(ones_a), 32'd0);
      chk("rst_b_sig",  32'(sig_b),  32'd0);
      chk("rst_b_busy", 32'(busy_b), 32'd0);

      // all-zero sweep against the model signature
      sweep_a(1'b0, "zeros");

      // reset after 100 accepted responses
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      valid_a = 1'b1;
      for (int i = 0; i < 100; i++) begin
         bit_a = i[0];
         tick();
      end
      chk("mid_vec",  32'(vec_a),  32'd100);
      chk("mid_ones", 32'(ones_a), 32'd50);
      rst   = 1'b1;
      bit_a = 1'b1;
      tick();
      rst     = 1'b0;
      valid_a = 1'b0;
      chk("midrst_busy", 32'(busy_a), 32'd0);
      chk("midrst_done", 32'(done_a), 32'd0);
      chk("midrst_sig",  32'(sig_a),  32'h0000FFFF);
      chk("midrst_vec",  32'(vec_a),  32'd0);
      chk("midrst_ones", 32'(ones_a), 32'd0);
      chk("midrst_pass", 32'(pass_a), 32'd0);
      tick();
      chk("midrst_no_done", 32'(done_a), 32'd0);
      chk("midrst_idle",    32'(busy_a), 32'd0);

      // fresh full sweep of ones after the reset
      sweep_a(1'b1, "ones");

      // small-configuration vector table
      // ungapped 1,0,0,0 with matching golden
      tbl.push_back(mk(1,0,0,8'h38, 8'h00,2'd0,3'd0,1,0,0));
      tbl.push_back(mk(0,1,1,8'h38, 8'h07,2'd1,3'd1,1,0,0));
      tbl.push_back(mk(0,1,0,8'h38, 8'h0E,2'd2,3'd1,1,0,0));
      tbl.push_back(mk(0,1,0,8'h38, 8'h1C,2'd3,3'd1,1,0,0));
      tbl.push_back(mk(0,1,0,8'h38, 8'h38,2'd0,3'd1,0,1,1));
      tbl.push_back(mk(0,0,0,8'h38, 8'h38,2'd0,3'd1,0,0,1));
      // same stream, wrong golden
      tbl.push_back(mk(1,0,0,8'h39, 8'h00,2'd0,3'd0,1,0,0));
      tbl.push_back(mk(0,1,1,8'h39, 8'h07,2'd1,3'd1,1,0,0));
      tbl.push_back(mk(0,1,0,8'h39, 8'h0E,2'd2,3'd1,1,0,0));
      tbl.push_back(mk(0,1,0,8'h39, 8'h1C,2'd3,3'd1,1,0,0));
      tbl.push_back(mk(0,1,0,8'h39, 8'h38,2'd0,3'd1,0,1,0));
      tbl.push_back(mk(0,0,0,8'h39, 8'h38,2'd0,3'd1,0,0,0));
      // gapped valid 1,0,0,1,1,0,1 with don't-care bits driven as 1
      tbl.push_back(mk(1,0,0,8'h38, 8'h00,2'd0,3'd0,1,0,0));
      tbl.push_back(mk(0,1,1,8'h38, 8'h07,2'd1,3'd1,1,0,0));
      tbl.push_back(mk(0,0,1,8'h38, 8'h07,2'd1,3'd1,1,0,0));
      tbl.push_back(mk(0,0,1,8'h38, 8'h07,2'd1,3'd1,1,0,0));
      tbl.push_back(mk(0,1,0,8'h38, 8'h0E,2'd2,3'd1,1,0,0));
      tbl.push_back(mk(0,1,0,8'h38, 8'h1C,2'd3,3'd1,1,0,0));
      tbl.push_back(mk(0,0,1,8'h38, 8'h1C,2'd3,3'd1,1,0,0));
      tbl.push_back(mk(0,1,0,8'h38, 8'h38,2'd0,3'd1,0,1,1));
      tbl.push_back(mk(0,0,0,8'h38, 8'h38,2'd0,3'd1,0,0,1));
      // start during RUN and DONE, then resp_valid in IDLE
      tbl.push_back(mk(1,0,0,8'h38, 8'h00,2'd0,3'd0,1,0,0));
      tbl.push_back(mk(1,1,1,8'h38, 8'h07,2'd1,3'd1,1,0,0));
      tbl.push_back(mk(1,1,0,8'h38, 8'h0E,2'd2,3'd1,1,0,0));
      tbl.push_back(mk(0,1,0,8'h38, 8'h1C,2'd3,3'd1,1,0,0));
      tbl.push_back(mk(0,1,0,8'h38, 8'h38,2'd0,3'd1,0,1,1));
      tbl.push_back(mk(1,1,1,8'h38, 8'h38,2'd0,3'd1,0,0,1));
      tbl.push_back(mk(0,1,1,8'h38, 8'h38,2'd0,3'd1,0,0,1));
      tbl.push_back(mk(0,1,1,8'h38, 8'h38,2'd0,3'd1,0,0,1));

      foreach (tbl[i]) begin
         start_b = tbl[i].start;
         valid_b = tbl[i].valid;
         bit_b   = tbl[i].bitv;
         esig_b  = tbl[i].esig;
         tick();
         chk($sformatf("row%0d_sig",  i), 32'(sig_b),  32'(tbl[i].sig));
         chk($sformatf("row%0d_vec",  i), 32'(vec_b),  32'(tbl[i].vec));
         chk($sformatf("row%0d_ones", i), 32'(ones_b), 32'(tbl[i].ones));
         chk($sformatf("row%0d_busy", i), 32'(busy_b), 32'(tbl[i].busy));
         chk($sformatf("row%0d_done", i), 32'(done_b), 32'(tbl[i].done));
         chk($sformatf("row%0d_pass", i), 32'(pass_b), 32'(tbl[i].pass));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/exhaustive_response_checker.md
Name: exhaustive_response_checker

Overview:
- Receiving end of the exhaustive-stimulus test flow.
- The stimulus side walks all 2^N_IN input combinations and presents one DUT output bit per vector. This block accepts those bits through a valid strobe and tracks the vector index.
- It compacts the response stream into a serial CRC signature and counts the ones.
- At the end of the sweep it reports pass/fail against a golden signature, replacing manual inspection of printed output.

Parameters:
- N_IN, 9: number of DUT inputs; the sweep length is 2^N_IN vectors.
- SIG_W, 16: signature width in bits.
- POLY, 16'h1021: CRC feedback polynomial, SIG_W bits wide.
- SEED, 16'hFFFF: signature value loaded at start, SIG_W bits wide.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- resp_valid  in  1  resp_bit is valid this cycle.
- resp_bit  in  1  DUT output for the current vector.
- expected_sig  in  SIG_W  golden signature; sampled in the cycle the last response is accepted.
- vec_idx  out  N_IN  index of the next vector expected.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  result of the last completed sweep.
- signature  out  SIG_W  current or final signature.
- ones_count  out  N_IN+1  number of accepted responses equal to 1.

Behaviour:
- Reset: the following take effect on the clock edge with rst high.
  - State goes to IDLE.
  - vec_idx=0, busy=0, done=0, pass=0, signature=SEED, ones_count=0.
  - rst overrides every other input.
  - Reset mid-sweep discards all partial results; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - resp_valid is ignored; outputs hold the last sweep's values.
  - start=1: go to RUN; load signature=SEED, vec_idx=0, ones_count=0; clear pass.
- RUN:
  - busy=1.
  - On each cycle with resp_valid=1:
    - fb = signature[SIG_W-1] ^ resp_bit.
    - signature <= (signature << 1) ^ (fb ? POLY : 0).
    - ones_count += resp_bit.
    - vec_idx += 1, modulo 2^N_IN.
  - resp_valid=0 cycles leave all state unchanged (stalls are allowed).
  - start is ignored while in RUN.
  - Acceptance of the vector with vec_idx = 2^N_IN-1:
    - Go to DONE next cycle.
    - vec_idx wraps to 0.
    - pass <= (updated signature == expected_sig), registered in the same edge.
- DONE:
  - Lasts exactly one cycle, with done=1 and busy=0; resp_valid is ignored.
  - Then returns to IDLE.
  - A start asserted during the DONE cycle is ignored and must be re-issued in IDLE.
- Latency: from start to busy is 1 cycle. From the last accepted response to the done pulse is 1 cycle; pass is valid in the done cycle and holds until the next start or rst.
- Widths:
  - ones_count is N_IN+1 bits, so the all-ones sweep gives 2^N_IN with no overflow.
  - The signature is computed modulo the polynomial in SIG_W bits.
- Output registration: all outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then start, then 512 responses of 0 with resp_valid high every cycle, and expected_sig set to the value computed by a bench model:
  - busy=1 for 512 cycles, then done pulses once with pass=1.
  - ones_count=0 and vec_idx=0.
- Small configuration N_IN=2, SIG_W=8, POLY=8'h07, SEED=8'h00; responses 1,0,0,0:
  - signature steps through 07, 0E, 1C, 38.
  - expected_sig=8'h38 gives pass=1 and ones_count=1.
  - expected_sig=8'h39 gives pass=0.
- Same small configuration with resp_valid gapped as 1,0,0,1,1,0,1 and bits 1,x,x,0,0,x,0:
  - result is identical to the ungapped run (signature 8'h38).
  - vec_idx advances only on valid cycles.
- Start pulsed during RUN and during the DONE cycle:
  - no restart, and the final signature is unchanged.
  - resp_valid in IDLE leaves signature and ones_count untouched.
- rst asserted after 100 accepted responses in the default configuration:
  - next cycle: IDLE, signature=16'hFFFF, vec_idx=0, ones_count=0, pass=0, no done pulse.
  - a new start followed by a full sweep completes normally.
- All-ones sweep in the default configuration:
  - ones_count=512 (10'h200).
  - vec_idx wraps to 0.
  - done is asserted for exactly one cycle.
